// File: rtl/mul32_seq_shift_add_if.sv
// Operand/result bundle for mul32_seq_shift_add: start request with operands, abort, and busy/done/product status.
// The master modport drives requests; the slave modport is the multiplier side.
interface mul32_seq_shift_add_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        abort;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (
        output start, multiplicand, multiplier, abort,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier, abort,
        output busy, done, product
    );
endinterface

// File: rtl/mul32_seq_shift_add.sv
// Sequential 32x32->64 unsigned shift-add multiplier, one operand bit per RUN cycle, 17-bit slice accumulate.
// Latency: start in cycle 0 -> done pulse in cycle 33 (earlier with MUL32_SEQ_EARLY_TERM_EN defined).
// Backpressure: none; start is only sampled in IDLE, abort cancels a RUN, product holds until the next completion.
module mul32_seq_shift_add #(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    mul32_seq_shift_add_if.slave      bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [31:0] a_q,       a_d;
    logic [63:0] p_q,       p_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [63:0] product_q, product_d;

    logic [31:0] addend;
    logic [16:0] lo_sum;
    logic [16:0] hi_sum;
    logic [32:0] s_sum;
    logic [63:0] p_step;

`ifdef MUL32_SEQ_EARLY_TERM_EN
    logic        rest_zero;
    logic [5:0]  bulk_sh;
    logic [63:0] p_bulk;
`endif

    // The low slice carry feeds the high slice; the high slice carry-out is the 33rd sum bit.
    always_comb begin
        addend = p_q[0] ? a_q : 32'h0;
        lo_sum = {1'b0, p_q[47:32]} + {1'b0, addend[15:0]};
        hi_sum = {1'b0, p_q[63:48]} + {1'b0, addend[31:16]} + {16'h0, lo_sum[16]};
        s_sum  = {hi_sum, lo_sum[15:0]};
        p_step = {s_sum, p_q[31:1]};
    end

`ifdef MUL32_SEQ_EARLY_TERM_EN
    // Multiplier bits not yet consumed sit in P[31-cnt:0]; when all zero the remaining steps only shift.
    always_comb begin
        rest_zero = ((p_q[31:0] << cnt_q) == 32'h0);
        bulk_sh   = 6'd32 - {1'b0, cnt_q};
        p_bulk    = p_q >> bulk_sh;
    end
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.multiplicand;
                    p_d     = {32'h0, bus.multiplier};
                    cnt_d   = 5'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
`ifdef MUL32_SEQ_EARLY_TERM_EN
                end else if (rest_zero) begin
                    p_d       = p_bulk;
                    product_d = p_bulk;
                    state_d   = ST_DONE;
                end else begin
`else
                end else begin
`endif
                    p_d   = p_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        product_d = p_step;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            a_q       <= 32'h0;
            p_q       <= 64'h0;
            cnt_q     <= 5'd0;
            product_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_mul32_seq_shift_add.sv
// Directed bench for mul32_seq_shift_add: latency, products, abort, back-to-back starts and mid-run reset.
module tb_mul32_seq_shift_add;

    logic clk;
    logic rst;
    mul32_seq_shift_add_if bus ();

    mul32_seq_shift_add #(.UUID(0), .NAME("dut")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected done cycle for a start accepted in cycle 0.
    function automatic int exp_lat(input logic [31:0] b);
        int m;
`ifdef MUL32_SEQ_EARLY_TERM_EN
        m = -1;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        if (m < 0) return 2;
        return (m + 3 > 33) ? 33 : m + 3;
`else
        m = 0;
        if (b == 32'hFFFF_FFFF) m = 1;
        return 33 + m - m;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation in the current cycle (cycle 0) and follows it to its done pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_p, input int lat, input string nm);
        int cyc;
        int done_cyc;
        int busy_err;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        busy_err = 0;
        while (cyc <= 40 && done_cyc < 0) begin
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                if (bus.busy !== 1'b0) busy_err++;
            end else begin
                if (bus.busy !== 1'b1) busy_err++;
                tick();
                cyc++;
            end
        end
        checks++;
        if (done_cyc !== lat) begin
            failures++;
            $display("FAIL %s_latency: done cycle %0d, expected %0d", nm, done_cyc, lat);
        end
        checks++;
        if (busy_err !== 0) begin
            failures++;
            $display("FAIL %s_busy: %0d cycles with wrong busy, expected 0", nm, busy_err);
        end
        checks++;
        if (bus.product !== exp_p) begin
            failures++;
            $display("FAIL %s_product: got %h, expected %h", nm, bus.product, exp_p);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_done: done=%b busy=%b, expected 0 0", nm, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.multiplicand = 32'h0;
        bus.multiplier   = 32'h0;
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%h, expected 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        run_op(32'd3, 32'd5, 64'h0F, exp_lat(32'd5), "mul_3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, exp_lat(32'hFFFF_FFFF), "mul_ones");
        run_op(32'h1234_5678, 32'h0, 64'h0, exp_lat(32'h0), "mul_zero");
        run_op(32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800, exp_lat(32'h100), "mul_shift8");
    endtask

    task automatic test_abort();
        logic [31:0] b2;
        int early_done;
`ifdef MUL32_SEQ_EARLY_TERM_EN
        b2 = 32'h4000_0004;
`else
        b2 = 32'h0000_0004;
`endif
        run_op(32'd7, 32'd9, 64'd63, exp_lat(32'd9), "mul_7x9");
        bus.multiplicand = 32'd2;
        bus.multiplier   = b2;
        bus.start        = 1'b1;
        tick();
        bus.start  = 1'b0;
        early_done = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done !== 1'b0) early_done++;
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || early_done !== 0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b done=%b early_done=%0d, expected 0 0 0",
                     bus.busy, bus.done, early_done);
        end
        checks++;
        if (bus.product !== 64'd63) begin
            failures++;
            $display("FAIL abort_product: got %h, expected %h", bus.product, 64'd63);
        end
        run_op(32'd6, 32'd7, 64'd42, exp_lat(32'd7), "after_abort");
    endtask

    task automatic test_back_to_back();
        int dcyc[$];
        int bad_prod;
        bus.multiplicand = 32'd1;
        bus.multiplier   = 32'h8000_0000;
        bus.start        = 1'b1;
        bad_prod         = 0;
        for (int c = 1; c <= 135; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                dcyc.push_back(c);
                if (bus.product !== 64'h8000_0000) bad_prod++;
            end
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (dcyc.size() !== 4) begin
            failures++;
            $display("FAIL b2b_count: %0d done pulses, expected 4", dcyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dcyc[k] !== 33 + 34 * k) begin
                    failures++;
                    $display("FAIL b2b_cycle%0d: done in cycle %0d, expected %0d", k, dcyc[k], 33 + 34 * k);
                end
            end
        end
        checks++;
        if (bad_prod !== 0 || bus.product !== 64'h8000_0000) begin
            failures++;
            $display("FAIL b2b_product: got %h with %0d bad, expected %h", bus.product, bad_prod, 64'h8000_0000);
        end
    endtask

    task automatic test_reset_midrun();
        int stray;
        bus.multiplicand = 32'hFFFF_FFFF;
        bus.multiplier   = 32'hFFFF_FFFF;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%h, expected 0 0 0",
                     bus.busy, bus.done, bus.product);
        end
        tick();
        rst   = 1'b1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL midrun_quiet: %0d cycles with busy/done, expected 0", stray);
        end
        run_op(32'd3, 32'd5, 64'h0F, exp_lat(32'd5), "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
